// File: rtl/fc_bias_act_serializer.sv
// Captures one packed fc_layer result vector plus biases, then emits one element per cycle
// after bias-add, arithmetic right shift, activation and saturation to N bits. Define FC_RELU_EN for ReLU.
module fc_bias_act_serializer #(
  parameter int N     = 8,
  parameter int J     = 3,
  parameter int K     = 3,
  parameter int SHIFT = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [J*(2*N+K-1)-1:0]                 wx,
  input  logic [J*N-1:0]                         bias,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [N-1:0]                           out_data,
  output logic [($clog2(J) > 0 ? $clog2(J) : 1)-1:0] out_idx,
  output logic                                   out_last
);

  localparam int WI = 2*N + K - 1;
  localparam int IW = ($clog2(J) > 0) ? $clog2(J) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  localparam logic signed [WI:0] MAXV = (WI+1)'((1 << (N-1)) - 1);
  localparam logic signed [WI:0] MINV = -MAXV - 1;
  localparam logic [IW-1:0]      LAST_IDX = IW'(J-1);

  logic [0:0]          state;
  logic [IW-1:0]       idx;
  logic [J*WI-1:0]     wx_q;
  logic [J*N-1:0]      bias_q;

  logic [WI-1:0]       wx_e;
  logic [N-1:0]        bias_e;
  logic signed [WI:0]  s;
  logic signed [WI:0]  t;
  logic [N-1:0]        act;
  logic                emit;

  assign emit      = (state == EMIT);
  assign in_ready  = (state == IDLE);
  assign out_valid = emit;
  assign out_idx   = idx;
  assign out_last  = emit && (idx == LAST_IDX);
  assign out_data  = emit ? act : '0;

  // WI+1 bits hold the sum of a WI-bit and an N-bit signed value without overflow.
  always_comb begin
    wx_e   = wx_q[int'(idx)*WI +: WI];
    bias_e = bias_q[int'(idx)*N +: N];
    s      = $signed({wx_e[WI-1], wx_e}) + $signed({{(WI+1-N){bias_e[N-1]}}, bias_e});
    t      = s >>> SHIFT;
    act    = t[N-1:0];
`ifdef FC_RELU_EN
    if (t < 0)
      act = '0;
    else if (t > MAXV)
      act = MAXV[N-1:0];
`else
    if (t > MAXV)
      act = MAXV[N-1:0];
    else if (t < MINV)
      act = MINV[N-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      wx_q   <= '0;
      bias_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            wx_q   <= wx;
            bias_q <= bias;
            idx    <= '0;
            state  <= EMIT;
          end
        end
        default: begin
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_bias_act_serializer.sv
// Directed bench for fc_bias_act_serializer: N=8, J=3, K=3, with SHIFT=0 and SHIFT=2 instances.
module tb_fc_bias_act_serializer;

`ifdef FC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [53:0] wx = '0;
  logic [23:0] bias = '0;
  logic        out_valid, out_ready = 1'b1, out_last;
  logic [7:0]  out_data;
  logic [1:0]  out_idx;

  logic        in_valid2 = 1'b0, in_ready2;
  logic [53:0] wx2 = '0;
  logic [23:0] bias2 = '0;
  logic        out_valid2, out_last2;
  logic [7:0]  out_data2;
  logic [1:0]  out_idx2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fc_bias_act_serializer #(.N(8), .J(3), .K(3), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .wx(wx), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last)
  );

  fc_bias_act_serializer #(.N(8), .J(3), .K(3), .SHIFT(2)) dut_sh2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .wx(wx2), .bias(bias2),
    .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2), .out_idx(out_idx2),
    .out_last(out_last2)
  );

  function automatic logic [53:0] pk_wx(input int a, input int b, input int c);
    return {18'(c), 18'(b), 18'(a)};
  endfunction

  function automatic logic [23:0] pk_b(input int a, input int b, input int c);
    return {8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_data"}, int'($signed(out_data)), 0);
    chk({tag, "_out_last"}, int'(out_last), 0);
  endtask

  // Present one vector for one cycle starting at a negedge; element 0 is visible at the next negedge.
  task automatic send(input logic [53:0] w, input logic [23:0] b);
    @(negedge clk);
    wx = w;
    bias = b;
    in_valid = 1'b1;
    #1;
    chk("capture_cycle_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic chk_elem(input string tag, input int i, input int exp);
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_idx"}, int'(out_idx), i);
    chk({tag, "_data"}, int'($signed(out_data)), exp);
    chk({tag, "_last"}, int'(out_last), (i == 2) ? 1 : 0);
  endtask

  task automatic emit3(input string tag, input int e0, input int e1, input int e2);
    @(negedge clk); chk_elem({tag, "_e0"}, 0, e0);
    @(negedge clk); chk_elem({tag, "_e1"}, 1, e1);
    @(negedge clk); chk_elem({tag, "_e2"}, 2, e2);
    @(negedge clk); chk_idle({tag, "_after"});
  endtask

  initial begin
    #3;
    chk_idle("reset");
    chk("reset_idx", int'(out_idx), 0);
    chk("reset2_in_ready", int'(in_ready2), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    send(pk_wx(-21, 29, 16), pk_b(0, 0, 0));
    if (RELU) emit3("relu_basic", 0, 29, 16);
    else      emit3("basic", -21, 29, 16);

    send(pk_wx(-21, 29, 16), pk_b(25, -30, 0));
    if (RELU) emit3("relu_bias", 4, 0, 16);
    else      emit3("bias", 4, -1, 16);

    send(pk_wx(300, -300, 127), pk_b(0, 0, 1));
    if (RELU) emit3("relu_sat", 127, 0, 127);
    else      emit3("sat", 127, -128, 127);

    // Backpressure at idx 1 with a competing in_valid pulse that must be ignored.
    send(pk_wx(-21, 29, 16), pk_b(0, 0, 0));
    @(negedge clk);
    chk_elem("bp_e0", 0, RELU ? 0 : -21);
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk_elem($sformatf("bp_hold%0d", c), 1, 29);
      if (c == 1) begin
        wx = pk_wx(300, -300, 127);
        in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    chk_elem("bp_hold_last", 1, 29);
    @(negedge clk);
    chk_elem("bp_e2", 2, 16);
    @(negedge clk);
    chk_idle("bp_after");
    @(negedge clk);
    chk_idle("bp_no_ghost");

    // Asynchronous reset in the middle of emission.
    send(pk_wx(-21, 29, 16), pk_b(0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_pre_idx", int'(out_idx), 1);
    rst = 1'b1;
    #1;
    chk_idle("rst_mid");
    chk("rst_mid_idx", int'(out_idx), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("rst_release");
    @(negedge clk);
    chk_idle("rst_release2");
    send(pk_wx(-21, 29, 16), pk_b(25, -30, 0));
    if (RELU) emit3("post_rst_relu", 4, 0, 16);
    else      emit3("post_rst", 4, -1, 16);

    // SHIFT=2 instance: floor rounding of negatives.
    @(negedge clk);
    wx2 = pk_wx(-21, 29, 16);
    bias2 = pk_b(0, 0, 0);
    in_valid2 = 1'b1;
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      int exp_sh;
      @(negedge clk);
      exp_sh = (i == 0) ? (RELU ? 0 : -6) : ((i == 1) ? 7 : 4);
      chk($sformatf("sh2_e%0d_valid", i), int'(out_valid2), 1);
      chk($sformatf("sh2_e%0d_idx", i), int'(out_idx2), i);
      chk($sformatf("sh2_e%0d_data", i), int'($signed(out_data2)), exp_sh);
      chk($sformatf("sh2_e%0d_last", i), int'(out_last2), (i == 2) ? 1 : 0);
    end
    @(negedge clk);
    chk("sh2_after_in_ready", int'(in_ready2), 1);
    chk("sh2_after_out_valid", int'(out_valid2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
